// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage sitting directly after the program counter. It owns
// the PC, presents it to instruction memory, and captures the returned word
// into the IF/ID pipeline register. Branch redirects from decode, stalls from
// the hazard unit and a HALT encoding in the fetched stream steer the stage.
//
// Ports
//   clk            rising-edge clock for all state
//   reset          synchronous, active-high reset (overrides every input)
//   stall          hold PC and IF/ID (ignored when branchPresent is high)
//   branchPresent  redirect fetch to branchTarget this cycle
//   branchTarget   absolute redirect address (low two bits are dropped)
//   imemRdata      instruction word for imemAddr, zero latency
//   imemAddr       instruction memory address (equals PC)
//   pcOut          current PC
//   ifidPC         PC of the instruction held in IF/ID
//   ifidInstr      instruction held in IF/ID
//   ifidValid      IF/ID holds a real instruction
//   halted         high while fetch is stopped on a HALT word
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0002_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branchPresent,
    input  logic [31:0] branchTarget,
    input  logic [31:0] imemRdata,
    output logic [31:0] imemAddr,
    output logic [31:0] pcOut,
    output logic [31:0] ifidPC,
    output logic [31:0] ifidInstr,
    output logic        ifidValid,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_BOOT = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_pc;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;
    logic        r_halted;

    logic [31:0] w_pc_next;
    logic [31:0] w_ifid_pc_next;
    logic [31:0] w_ifid_instr_next;
    logic        w_ifid_valid_next;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;
    logic        w_is_halt;

    // Sequential increment wraps modulo 2^32; redirects are forced word-aligned
    // so PC[1:0] can never become non-zero.
    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_redirect_pc = branchTarget & 32'hFFFF_FFFC;
    assign w_is_halt     = (imemRdata == HALT_INSTR);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and next-datapath decode; everything holds unless a case
    // below says otherwise.
    always_comb begin
        w_next_state      = r_state;
        w_pc_next         = r_pc;
        w_ifid_pc_next    = r_ifid_pc;
        w_ifid_instr_next = r_ifid_instr;
        w_ifid_valid_next = r_ifid_valid;

        case (r_state)
            S_BOOT: begin
                // One idle cycle after reset: nothing captured, PC holds,
                // stall and branch are not looked at.
                w_next_state = S_RUN;
            end

            S_RUN: begin
                if (branchPresent) begin
                    // Redirect wins over stall; the word on imemRdata is the
                    // wrong-path fetch and is dropped even if it is HALT.
                    w_pc_next         = w_redirect_pc;
                    w_ifid_pc_next    = 32'h0000_0000;
                    w_ifid_instr_next = NOP_INSTR;
                    w_ifid_valid_next = 1'b0;
                end else if (stall) begin
                    w_pc_next = r_pc;
                end else begin
                    w_ifid_pc_next    = r_pc;
                    w_ifid_instr_next = imemRdata;
                    w_ifid_valid_next = 1'b1;
                    if (w_is_halt) begin
                        // HALT is handed to decode as a real instruction, but
                        // fetch stops advancing from here on.
                        w_pc_next    = r_pc;
                        w_next_state = S_HALT;
                    end else begin
                        w_pc_next = w_pc_plus4;
                    end
                end
            end

            S_HALT: begin
                if (branchPresent) begin
                    // An older branch squashes the HALT and restarts fetch.
                    w_pc_next         = w_redirect_pc;
                    w_ifid_pc_next    = 32'h0000_0000;
                    w_ifid_instr_next = NOP_INSTR;
                    w_ifid_valid_next = 1'b0;
                    w_next_state      = S_RUN;
                end else if (stall) begin
                    // Keep the delivered HALT visible while decode is stalled.
                    w_pc_next = r_pc;
                end else begin
                    // Decode has consumed the HALT; feed bubbles, keep its PC.
                    w_ifid_instr_next = NOP_INSTR;
                    w_ifid_valid_next = 1'b0;
                end
            end

            default: begin
                // Unreachable encoding: restart cleanly through BOOT.
                w_next_state      = S_BOOT;
                w_pc_next         = RESET_PC;
                w_ifid_pc_next    = 32'h0000_0000;
                w_ifid_instr_next = NOP_INSTR;
                w_ifid_valid_next = 1'b0;
            end
        endcase
    end

    // PC and IF/ID pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_ifid_pc    <= 32'h0000_0000;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else begin
            r_pc         <= w_pc_next;
            r_ifid_pc    <= w_ifid_pc_next;
            r_ifid_instr <= w_ifid_instr_next;
            r_ifid_valid <= w_ifid_valid_next;
        end
    end

    // Registered halted flag, tracking entry into and exit from HALT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else begin
            r_halted <= (w_next_state == S_HALT);
        end
    end

    assign imemAddr  = r_pc;
    assign pcOut     = r_pc;
    assign ifidPC    = r_ifid_pc;
    assign ifidInstr = r_ifid_instr;
    assign ifidValid = r_ifid_valid;
    assign halted    = r_halted;

endmodule
